// File: rtl/uart_pkg.sv
// Shared UART constants and receive FSM state encoding, used by the receiver and transmitter.
package uart_pkg;

    localparam int unsigned OVERSAMPLE      = 16;
    localparam int unsigned MID_TICK        = 7;
    localparam int unsigned DBIT_DEFAULT    = 8;
    localparam int unsigned SB_TICK_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for asynchronous single-bit inputs, with a configurable reset value.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic clear,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (clear) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, mid-bit sampling, start-glitch rejection, framing error flag.
// Optional parity bit and parity_odd input when UART_RX_PARITY_EN is defined.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DBIT    = DBIT_DEFAULT,
    parameter int unsigned SB_TICK = SB_TICK_DEFAULT
) (
    input  logic            clk,
    input  logic            clear,
    input  logic            rx,
    input  logic            s_tick,
`ifdef UART_RX_PARITY_EN
    input  logic            parity_odd,
`endif
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            parity_err
);

    // Tick counter must cover both the 16-tick bit period and the stop period.
    localparam int unsigned SB_W = $clog2(SB_TICK);
    localparam int unsigned SW   = (SB_W > 4) ? SB_W : 4;
    localparam int unsigned NW   = $clog2(DBIT);

    logic            w_rx_s;
    rx_state_t       r_state;
    logic [SW-1:0]   r_s;
    logic [NW-1:0]   r_n;
    logic [DBIT-1:0] r_b;
    logic [DBIT-1:0] r_dout;
    logic            r_done;
    logic            r_ferr;
`ifdef UART_RX_PARITY_EN
    logic            r_p;
    logic            r_perr;
`endif

    uart_sync2 #(.RST_VAL(1'b1)) u_sync_rx (
        .clk   (clk),
        .clear (clear),
        .i_d   (rx),
        .o_q   (w_rx_s)
    );

    always_ff @(posedge clk) begin
        if (clear) begin
            r_state <= ST_IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_b     <= '0;
            r_dout  <= '0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_p     <= 1'b0;
            r_perr  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_rx_s) begin
                        r_s     <= '0;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (s_tick) begin
                        if (r_s == SW'(MID_TICK)) begin
                            if (!w_rx_s) begin
                                r_s     <= '0;
                                r_n     <= '0;
                                r_state <= ST_DATA;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_s <= r_s + SW'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (s_tick) begin
                        if (r_s == SW'(OVERSAMPLE - 1)) begin
                            r_s <= '0;
                            r_b <= {w_rx_s, r_b[DBIT-1:1]};
                            if (r_n == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                                r_state <= ST_PARITY;
`else
                                r_state <= ST_STOP;
`endif
                            end else begin
                                r_n <= r_n + NW'(1);
                            end
                        end else begin
                            r_s <= r_s + SW'(1);
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (s_tick) begin
                        if (r_s == SW'(OVERSAMPLE - 1)) begin
                            r_s     <= '0;
                            r_p     <= w_rx_s;
                            r_state <= ST_STOP;
                        end else begin
                            r_s <= r_s + SW'(1);
                        end
                    end
                end
`endif
                ST_STOP: begin
                    // Stop decision uses the sample taken on the final stop tick.
                    if (s_tick) begin
                        if (r_s == SW'(SB_TICK - 1)) begin
                            r_dout  <= r_b;
                            r_ferr  <= ~w_rx_s;
`ifdef UART_RX_PARITY_EN
                            r_perr  <= (^r_b) ^ r_p ^ parity_odd;
`endif
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_s <= r_s + SW'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign dout         = r_dout;
    assign rx_done_tick = r_done;
    assign frame_err    = r_ferr;
`ifdef UART_RX_PARITY_EN
    assign parity_err   = r_perr;
`else
    assign parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames against a frame-level model.
module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int BIT_CLK = 64;
    localparam int EXP_LAT = 2 + 4 * (8 + 16 * 8 + (PAR_EN ? 16 : 0) + 16);

    typedef struct packed {
        logic [7:0] d;
        logic       ferr;
        logic       perr;
    } frame_t;

    logic       clk;
    logic       clear;
    logic       rx;
    logic       s_tick;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       frame_err;
    logic       parity_err;
`ifdef UART_RX_PARITY_EN
    logic       parity_odd;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t_start = 0;
    int last_done_cyc = -1;
    int wide_cnt = 0;
    int tick_div = 0;
    bit prev_done = 1'b0;
    frame_t exp_q[$];
    frame_t obs_q[$];

    uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
        .clk          (clk),
        .clear        (clear),
        .rx           (rx),
        .s_tick       (s_tick),
`ifdef UART_RX_PARITY_EN
        .parity_odd   (parity_odd),
`endif
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err),
        .parity_err   (parity_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Baud strobe: one clk high every 4 clk.
    initial begin
        s_tick = 1'b0;
        forever begin
            @(negedge clk);
            tick_div = (tick_div + 1) % 4;
            s_tick = (tick_div == 0);
        end
    end

    always @(negedge clk) begin
        if (rx_done_tick) begin
            obs_q.push_back(frame_t'{dout, frame_err, parity_err});
            last_done_cyc = cyc;
            if (prev_done) wide_cnt++;
        end
        prev_done = rx_done_tick;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b, input int n);
        rx = b;
        repeat (n) @(negedge clk);
    endtask

    // Sends one frame; the stop level is held for 3/4 of the bit, then the line idles high.
    task automatic send_frame(input logic [7:0] d, input bit stop, input bit pflip);
        logic p;
        p = (^d) ^ pflip;
`ifdef UART_RX_PARITY_EN
        p = p ^ parity_odd;
`endif
        t_start = cyc;
        drive_bit(1'b0, BIT_CLK);
        for (int i = 0; i < 8; i++) drive_bit(d[i], BIT_CLK);
        if (PAR_EN) drive_bit(p, BIT_CLK);
        drive_bit(stop, 48);
        drive_bit(1'b1, 16);
        exp_q.push_back(frame_t'{d, ~stop, PAR_EN ? pflip : 1'b0});
    endtask

    task automatic check_frames(input string tag);
        frame_t e;
        frame_t o;
        chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            chk({tag, "_dout"}, 32'(o.d), 32'(e.d));
            chk({tag, "_ferr"}, 32'(o.ferr), 32'(e.ferr));
            chk({tag, "_perr"}, 32'(o.perr), 32'(e.perr));
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        int lat;
        int gap;
        clear = 1'b1;
        rx    = 1'b1;
`ifdef UART_RX_PARITY_EN
        parity_odd = 1'b0;
`endif
        repeat (4) @(negedge clk);
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_done", 32'(rx_done_tick), 32'h0);
        chk("rst_ferr", 32'(frame_err), 32'h0);
        chk("rst_perr", 32'(parity_err), 32'h0);
        clear = 1'b0;
        repeat (10) @(negedge clk);

        send_frame(8'hA5, 1'b1, 1'b0);
        lat = last_done_cyc - t_start;
        chk("a5_latency_window", 32'((lat >= EXP_LAT - 4) && (lat <= EXP_LAT + 4)), 32'h1);
        check_frames("a5");
        drive_bit(1'b1, 40);

        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        check_frames("b2b");
        drive_bit(1'b1, 40);

        drive_bit(1'b0, 12);
        drive_bit(1'b1, 10 * BIT_CLK);
        check_frames("glitch");
        send_frame(8'h3C, 1'b1, 1'b0);
        check_frames("after_glitch");
        drive_bit(1'b1, 40);

        send_frame(8'h55, 1'b0, 1'b0);
        drive_bit(1'b1, BIT_CLK);
        send_frame(8'h96, 1'b1, 1'b0);
        check_frames("ferr");
        drive_bit(1'b1, 40);

        // Abort 0x81 halfway through data bit 4 with clear; the line then idles.
        drive_bit(1'b0, BIT_CLK);
        drive_bit(1'b1, BIT_CLK);
        for (int i = 0; i < 3; i++) drive_bit(1'b0, BIT_CLK);
        drive_bit(1'b0, 32);
        clear = 1'b1;
        drive_bit(1'b1, 1);
        clear = 1'b0;
        chk("clr_dout", 32'(dout), 32'h0);
        chk("clr_ferr", 32'(frame_err), 32'h0);
        chk("clr_perr", 32'(parity_err), 32'h0);
        drive_bit(1'b1, 12 * BIT_CLK);
        check_frames("clr_nopulse");
        send_frame(8'h7E, 1'b1, 1'b0);
        check_frames("after_clr");
        drive_bit(1'b1, 40);

        send_frame(8'h03, 1'b1, 1'b0);
        check_frames("par_ok");
        drive_bit(1'b1, 40);
        send_frame(8'h03, 1'b1, 1'b1);
        check_frames("par_bad");
        drive_bit(1'b1, 40);

        for (int k = 0; k < 10; k++) begin
            gap = int'($urandom_range(40, 120));
`ifdef UART_RX_PARITY_EN
            parity_odd = 1'($urandom_range(1));
`endif
            send_frame(8'($urandom), ($urandom_range(3) != 0), 1'($urandom_range(1)));
            check_frames("rand");
            drive_bit(1'b1, gap);
        end

        chk("pulse_width", 32'(wide_cnt), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
